// File: rtl/sdram_cmd_gen.sv
// SDRAM command generator: orders PALL/REF/MRS/ACT/PRE/READ/WRITE into the command FIFO,
// tracking open rows per bank, running power-up init and inserting auto-refresh.
package sdram_cmd_pkg;
    typedef enum logic [2:0] {
        CMD_NOP, CMD_PALL, CMD_REF, CMD_MRS, CMD_ACT, CMD_PRE, CMD_READ, CMD_WRITE
    } cmd_e;

    typedef struct packed {
        cmd_e        cmd;
        logic [1:0]  ba;
        logic [8:0]  column;
        logic [15:0] data;
    } data_t;
endpackage

module sdram_cmd_gen
    import sdram_cmd_pkg::*;
#(
    parameter int INIT_REFS = 2,
    parameter int REF_MAX   = 3
) (
    input  logic        clkSDRAM,
    input  logic        reset,
    input  logic        icnt_ovf,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_id,
    input  logic        full,
    output logic        fifo_wrreq,
    output data_t       fifo_in,
    output logic        init_done
);
    typedef enum logic [3:0] {
        INIT_WAIT, I_PALL, I_REF, I_MRS, IDLE, R_PALL, R_REF, S_PRE, S_ACT, S_RW
    } state_e;

    localparam logic [1:0] REF_SAT  = 2'(REF_MAX);
    localparam logic [1:0] INIT_END = 2'(INIT_REFS - 1);

    state_e            state;
    logic [3:0]        bank_open;
    logic [3:0][12:0]  open_row;
    logic [1:0]        ref_cnt;
    logic [1:0]        init_cnt;
    logic              h_we;
    logic [1:0]        h_ba;
    logic [12:0]       h_row;
    logic [8:0]        h_col;
    logic [15:0]       h_wdata;
    logic [1:0]        h_id;

    logic       has_cmd, push, tick, ref_done;
    logic [1:0] in_ba;
    logic       row_hit;

    assign has_cmd = (state != INIT_WAIT) && (state != IDLE);
    assign push       = has_cmd & ~full;
    assign fifo_wrreq = push;
    assign req_ready  = (state == S_RW) & ~full;
    assign tick       = icnt_ovf & init_done;
    assign ref_done   = (state == R_REF) & push;
    assign in_ba      = req_addr[23:22];
    assign row_hit    = bank_open[in_ba] && (open_row[in_ba] == req_addr[21:9]);

    always_comb begin
        fifo_in = '{cmd: CMD_NOP, ba: 2'd0, column: 9'd0, data: 16'd0};
        case (state)
            I_PALL, R_PALL: fifo_in.cmd = CMD_PALL;
            I_REF, R_REF:   fifo_in.cmd = CMD_REF;
            I_MRS:          fifo_in.cmd = CMD_MRS;
            S_PRE: begin
                fifo_in.cmd = CMD_PRE;
                fifo_in.ba  = h_ba;
            end
            S_ACT: begin
                fifo_in.cmd  = CMD_ACT;
                fifo_in.ba   = h_ba;
                fifo_in.data = {3'd0, h_row};
            end
            S_RW: begin
                fifo_in.cmd    = h_we ? CMD_WRITE : CMD_READ;
                fifo_in.ba     = h_ba;
                fifo_in.column = h_col;
                fifo_in.data   = h_we ? h_wdata : {14'd0, h_id};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkSDRAM or posedge reset) begin
        if (reset) begin
            state     <= INIT_WAIT;
            bank_open <= '0;
            open_row  <= '0;
            ref_cnt   <= '0;
            init_cnt  <= '0;
            init_done <= 1'b0;
            h_we      <= 1'b0;
            h_ba      <= '0;
            h_row     <= '0;
            h_col     <= '0;
            h_wdata   <= '0;
            h_id      <= '0;
        end else begin
            // a tick landing on a REF push cancels out
            case ({tick, ref_done})
                2'b10:   if (ref_cnt != REF_SAT) ref_cnt <= ref_cnt + 2'd1;
                2'b01:   ref_cnt <= ref_cnt - 2'd1;
                default: ;
            endcase

            case (state)
                INIT_WAIT: if (icnt_ovf) state <= I_PALL;
                I_PALL: if (push) begin
                    bank_open <= '0;
                    state     <= I_REF;
                end
                I_REF: if (push) begin
                    if (init_cnt == INIT_END) begin
                        init_cnt <= '0;
                        state    <= I_MRS;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                I_MRS: if (push) begin
                    init_done <= 1'b1;
                    state     <= IDLE;
                end
                IDLE: begin
                    if (ref_cnt != 2'd0) begin
                        state <= R_PALL;
                    end else if (req_valid) begin
                        h_we    <= req_we;
                        h_ba    <= in_ba;
                        h_row   <= req_addr[21:9];
                        h_col   <= req_addr[8:0];
                        h_wdata <= req_wdata;
                        h_id    <= req_id;
                        if (row_hit)              state <= S_RW;
                        else if (bank_open[in_ba]) state <= S_PRE;
                        else                      state <= S_ACT;
                    end
                end
                R_PALL: if (push) begin
                    bank_open <= '0;
                    state     <= R_REF;
                end
                R_REF: if (push) begin
                    bank_open <= '0;
                    state     <= IDLE;
                end
                S_PRE: if (push) begin
                    bank_open[h_ba] <= 1'b0;
                    state           <= S_ACT;
                end
                S_ACT: if (push) begin
                    bank_open[h_ba] <= 1'b1;
                    open_row[h_ba]  <= h_row;
                    state           <= S_RW;
                end
                S_RW: if (push) state <= IDLE;
                default: state <= INIT_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_cmd_gen.sv
// Scoreboard bench for sdram_cmd_gen: a bank/row model queues expected commands,
// a negedge monitor pops and compares every FIFO push.
module tb_sdram_cmd_gen;
    import sdram_cmd_pkg::*;

    localparam int INIT_REFS = 2;
    localparam int REF_MAX   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icnt_ovf = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_id = '0;
    logic        full = 1'b0;
    logic        fifo_wrreq;
    data_t       fifo_in;
    logic        init_done;

    sdram_cmd_gen #(.INIT_REFS(INIT_REFS), .REF_MAX(REF_MAX)) dut (
        .clkSDRAM(clk), .reset(rst), .icnt_ovf(icnt_ovf),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .full(full), .fifo_wrreq(fifo_wrreq), .fifo_in(fifo_in), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        data_t d;
        bit    rdy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    // model state
    bit        m_init = 0;
    int        m_pend = 0;
    bit [3:0]  m_open = '0;
    bit [12:0] m_row [4];

    // full driver: 0 = follow full_force, 1 = toggle, 2 = random
    int full_mode = 0;
    bit full_force = 0;
    initial forever begin
        @(posedge clk);
        #2;
        case (full_mode)
            1:       full = ~full;
            2:       full = 1'($urandom_range(0, 1));
            default: full = full_force;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wrreq) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream: unexpected push %h", fifo_in);
                end else begin
                    e = q.pop_front();
                    if (fifo_in !== e.d || req_ready !== e.rdy) begin
                        failures++;
                        $display("FAIL stream: got %h ready=%b, want %h ready=%b",
                                 fifo_in, req_ready, e.d, e.rdy);
                    end
                end
            end else if (req_ready) begin
                checks++;
                failures++;
                $display("FAIL ready_no_push: req_ready=1 with fifo_wrreq=0");
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic push_exp(input cmd_e c, input logic [1:0] ba, input logic [8:0] col,
                            input logic [15:0] d, input bit rdy);
        exp_t x;
        x.d   = '{cmd: c, ba: ba, column: col, data: d};
        x.rdy = rdy;
        q.push_back(x);
    endtask

    task automatic flush_ref();
        repeat (m_pend) begin
            push_exp(CMD_PALL, 0, 0, 0, 0);
            push_exp(CMD_REF, 0, 0, 0, 0);
        end
        if (m_pend > 0) m_open = '0;
        m_pend = 0;
    endtask

    task automatic model_req(input bit we, input logic [23:0] addr,
                             input logic [15:0] wd, input logic [1:0] id);
        logic [1:0]  ba;
        logic [12:0] row;
        ba  = addr[23:22];
        row = addr[21:9];
        flush_ref();
        if (!(m_open[ba] && m_row[ba] == row)) begin
            if (m_open[ba]) push_exp(CMD_PRE, ba, 0, 0, 0);
            push_exp(CMD_ACT, ba, 0, {3'd0, row}, 0);
            m_open[ba] = 1;
            m_row[ba]  = row;
        end
        if (we) push_exp(CMD_WRITE, ba, addr[8:0], wd, 1);
        else    push_exp(CMD_READ, ba, addr[8:0], {14'd0, id}, 1);
    endtask

    task automatic drive(input bit we, input logic [23:0] addr,
                         input logic [15:0] wd, input logic [1:0] id);
        req_we = we; req_addr = addr; req_wdata = wd; req_id = id; req_valid = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout: no req_ready after %0d cycles", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input bit we, input logic [23:0] addr,
                          input logic [15:0] wd, input logic [1:0] id, output int n);
        model_req(we, addr, wd, id);
        drive(we, addr, wd, id);
        wait_ready(n);
    endtask

    task automatic tick();
        if (!m_init) begin
            push_exp(CMD_PALL, 0, 0, 0, 0);
            repeat (INIT_REFS) push_exp(CMD_REF, 0, 0, 0, 0);
            push_exp(CMD_MRS, 0, 0, 0, 0);
            m_init = 1;
        end else if (m_pend < REF_MAX) begin
            m_pend++;
        end
        @(negedge clk);
        icnt_ovf = 1'b1;
        @(negedge clk);
        icnt_ovf = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic logic [23:0] rnd_addr();
        logic [12:0] rows [3];
        rows[0] = 13'h0010; rows[1] = 13'h0011; rows[2] = 13'h1FFF;
        return {2'($urandom_range(0, 3)), rows[$urandom_range(0, 2)], 9'($urandom)};
    endfunction

    initial begin
        int n;
        logic [23:0] a;
        repeat (3) @(negedge clk);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_fifo_in", fifo_in, 0);
        rst = 1'b0;

        // 1+2: request waiting before init; read to closed bank 1
        a = {2'd1, 13'h123, 9'h008};
        drive(0, a, 16'h0, 2'd2);
        repeat (10) begin
            @(negedge clk);
            chk("ready_before_init", req_ready, 0);
        end
        chk("init_done_before_tick", init_done, 0);
        tick();
        model_req(0, a, 16'h0, 2'd2);
        wait_ready(n);
        chk("init_done_after", init_done, 1);

        // 3: row hit at full rate, then row miss
        do_req(1, {2'd1, 13'h123, 9'h011}, 16'hBEEF, 2'd0, n);
        chk("hit_latency", n, 2);
        do_req(1, {2'd1, 13'h456, 9'h022}, 16'hCAFE, 2'd0, n);
        drain();

        // 4: ticks under full saturate, then refreshes close all banks
        full_force = 1;
        repeat (4) begin
            tick();
            repeat (2) @(negedge clk);
        end
        chk("full_no_push", fifo_wrreq, 0);
        flush_ref();
        full_force = 0;
        drain();
        do_req(1, {2'd1, 13'h456, 9'h023}, 16'h1234, 2'd0, n);
        drain();

        // 5: mixed requests with full toggling, then random full with refresh ticks
        full_mode = 1;
        repeat (16) do_req(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom), 2'($urandom), n);
        full_mode = 2;
        repeat (24) begin
            if ($urandom_range(0, 4) == 0) tick();
            do_req(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom), 2'($urandom), n);
        end
        full_mode = 0;
        full_force = 0;
        flush_ref();
        drain();

        // 6: reset between ACT and READ push
        tick();
        flush_ref();
        drain();
        a = {2'd2, 13'h0007, 9'h005};
        push_exp(CMD_ACT, 2'd2, 0, 16'h0007, 0);
        drive(0, a, 16'h0, 2'd1);
        n = 0;
        while (!(fifo_wrreq && fifo_in.cmd == CMD_ACT) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("act_seen", (fifo_wrreq && fifo_in.cmd == CMD_ACT), 1);
        full_force = 1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst6_wrreq", fifo_wrreq, 0);
        chk("rst6_ready", req_ready, 0);
        chk("rst6_init_done", init_done, 0);
        chk("rst6_fifo_in", fifo_in, 0);
        chk("rst6_queue", q.size(), 0);
        q.delete();
        req_valid = 1'b0;
        full_force = 0;
        m_init = 0; m_pend = 0; m_open = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tick();
        drain();
        chk("init_done_rerun", init_done, 1);
        do_req(0, a, 16'h0, 2'd1, n);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
